// File: rtl/dmem_mmio_unit.sv
// Data memory behind the MEM stage: word RAM plus an MMIO block (cycle counter, countdown timer, GPIO).
// Define DMEM_BOUNDS_CHECK_EN to reject out-of-range RAM accesses and raise a sticky bus_err.
module dmem_mmio_unit #(
  parameter logic [31:0] RAM_BASE  = 32'h1001_0000,
  parameter int          RAM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = 32'h1001_F000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] DMEM_address,
  input  logic [31:0] write_data,
  input  logic        DMEM_WRITE,
  output logic [31:0] read_data,
  output logic [31:0] gpio_out,
  output logic        timer_irq,
  output logic        bus_err
);

  localparam int IDX_W = $clog2(RAM_WORDS);

  localparam logic [2:0] REG_CYCLE = 3'd0;
  localparam logic [2:0] REG_TLOAD = 3'd1;
  localparam logic [2:0] REG_TCTRL = 3'd2;
  localparam logic [2:0] REG_TVAL  = 3'd3;
  localparam logic [2:0] REG_TSTAT = 3'd4;
  localparam logic [2:0] REG_GPIO  = 3'd5;

  typedef enum logic [1:0] {T_IDLE, T_RUN, T_DONE} tstate_e;

  logic [31:0] mem_q [RAM_WORDS];

  logic [31:0] cycle_q, cycle_d;
  logic [31:0] tload_q, tload_d;
  logic [2:0]  tctrl_q, tctrl_d;
  logic [31:0] tval_q,  tval_d;
  logic        tstat_q, tstat_d;
  logic [31:0] gpio_q,  gpio_d;
  tstate_e     state_q, state_d;

  logic             mmio_hit;
  logic [2:0]       mmio_sel;
  logic [31:0]      ram_off;
  logic [IDX_W-1:0] ram_idx;
  logic             ram_in_range;
  logic             mmio_we;
  logic             ram_we;
  logic             tctrl_wr;
  logic             unused_ram_off;

  assign mmio_hit = (DMEM_address[31:5] == MMIO_BASE[31:5]);
  assign mmio_sel = DMEM_address[4:2];
  assign ram_off  = DMEM_address - RAM_BASE;
  assign ram_idx  = ram_off[IDX_W+1:2];
  assign unused_ram_off = ^{ram_off[31:IDX_W+2], ram_off[1:0]};

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS) << 2;
  logic bus_err_q, bus_err_d;

  // Unsigned offset compare also catches addresses below RAM_BASE (they wrap high).
  assign ram_in_range = (ram_off < RAM_BYTES);
  assign bus_err_d    = bus_err_q | (~mmio_hit & ~ram_in_range);

  always_ff @(posedge clock) begin
    if (reset) bus_err_q <= 1'b0;
    else       bus_err_q <= bus_err_d;
  end

  assign bus_err = bus_err_q;
`else
  assign ram_in_range = 1'b1;
  assign bus_err      = 1'b0;
`endif

  assign mmio_we  = DMEM_WRITE & mmio_hit;
  assign ram_we   = DMEM_WRITE & ~mmio_hit & ram_in_range;
  assign tctrl_wr = mmio_we & (mmio_sel == REG_TCTRL);

  // Loads see pre-edge state only; a same-cycle store is not forwarded.
  always_comb begin
    read_data = '0;
    if (mmio_hit) begin
      case (mmio_sel)
        REG_CYCLE: read_data = cycle_q;
        REG_TLOAD: read_data = tload_q;
        REG_TCTRL: read_data = {29'b0, tctrl_q};
        REG_TVAL:  read_data = tval_q;
        REG_TSTAT: read_data = {31'b0, tstat_q};
        REG_GPIO:  read_data = gpio_q;
        default:   read_data = '0;
      endcase
    end else if (ram_in_range) begin
      read_data = mem_q[ram_idx];
    end
  end

  always_comb begin
    cycle_d = cycle_q + 32'd1;
    tload_d = tload_q;
    tctrl_d = tctrl_q;
    tval_d  = tval_q;
    tstat_d = tstat_q;
    gpio_d  = gpio_q;
    state_d = state_q;

    if (mmio_we) begin
      case (mmio_sel)
        REG_TLOAD: tload_d = write_data;
        REG_GPIO:  gpio_d  = write_data;
        REG_TSTAT: if (write_data[0]) tstat_d = 1'b0;
        default:   ;
      endcase
    end

    // A TCTRL write overrides the countdown step in every state.
    if (tctrl_wr) begin
      tctrl_d = write_data[2:0];
      if (write_data[0]) begin
        tval_d  = tload_q;
        state_d = T_RUN;
      end else begin
        state_d = T_IDLE;
      end
    end else if (state_q == T_RUN) begin
      if (tval_q != '0) begin
        tval_d = tval_q - 32'd1;
      end else begin
        tstat_d = 1'b1;
        if (tctrl_q[1]) begin
          tval_d = tload_q;
        end else begin
          tctrl_d[0] = 1'b0;
          state_d    = T_DONE;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_q <= '0;
      tload_q <= '0;
      tctrl_q <= '0;
      tval_q  <= '0;
      tstat_q <= 1'b0;
      gpio_q  <= '0;
      state_q <= T_IDLE;
    end else begin
      cycle_q <= cycle_d;
      tload_q <= tload_d;
      tctrl_q <= tctrl_d;
      tval_q  <= tval_d;
      tstat_q <= tstat_d;
      gpio_q  <= gpio_d;
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock) begin
    if (ram_we) mem_q[ram_idx] <= write_data;
  end

  assign gpio_out  = gpio_q;
  assign timer_irq = tstat_q & tctrl_q[2];

endmodule

// File: tb/tb_dmem_mmio_unit.sv
// Directed bench for dmem_mmio_unit: RAM, cycle counter, timer, GPIO, reset and out-of-range stores.
module tb_dmem_mmio_unit;

  logic        clock;
  logic        reset;
  logic [31:0] DMEM_address;
  logic [31:0] write_data;
  logic        DMEM_WRITE;
  logic [31:0] read_data;
  logic [31:0] gpio_out;
  logic        timer_irq;
  logic        bus_err;

  int nchecks = 0;
  int nerrors = 0;

  localparam logic [31:0] A_CYCLE = 32'h1001_F000;
  localparam logic [31:0] A_TLOAD = 32'h1001_F004;
  localparam logic [31:0] A_TCTRL = 32'h1001_F008;
  localparam logic [31:0] A_TVAL  = 32'h1001_F00C;
  localparam logic [31:0] A_TSTAT = 32'h1001_F010;
  localparam logic [31:0] A_GPIO  = 32'h1001_F014;
  localparam logic [31:0] A_RSVD  = 32'h1001_F018;

  dmem_mmio_unit dut (
    .clock       (clock),
    .reset       (reset),
    .DMEM_address(DMEM_address),
    .write_data  (write_data),
    .DMEM_WRITE  (DMEM_WRITE),
    .read_data   (read_data),
    .gpio_out    (gpio_out),
    .timer_irq   (timer_irq),
    .bus_err     (bus_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    DMEM_address = a;
    write_data   = d;
    DMEM_WRITE   = 1'b1;
    tick();
    DMEM_WRITE   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    DMEM_address = a;
    DMEM_WRITE   = 1'b0;
    #1;
    check(tag, read_data, exp);
  endtask

  initial begin
    reset        = 1'b1;
    DMEM_address = 32'h1001_0000;
    write_data   = '0;
    DMEM_WRITE   = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_gpio", gpio_out, 32'h0);
    check("rst_irq", {31'b0, timer_irq}, 32'h0);
    check("rst_buserr", {31'b0, bus_err}, 32'h0);
    rd("rst_tval", A_TVAL, 32'h0);
    rd("rst_tctrl", A_TCTRL, 32'h0);
    rd("rst_tstat", A_TSTAT, 32'h0);
    reset = 1'b0;

    // Cycle counter
    rd("cycle_0", A_CYCLE, 32'd0);
    repeat (5) tick();
    rd("cycle_5", A_CYCLE, 32'd5);
    wr(A_CYCLE, 32'd123);
    rd("cycle_ro", A_CYCLE, 32'd6);
    rd("rsvd_rd", A_RSVD, 32'h0);

    // RAM store/load and no same-cycle bypass
    wr(32'h1001_0010, 32'hDEAD_BEEF);
    rd("ram_rd", 32'h1001_0010, 32'hDEAD_BEEF);
    DMEM_address = 32'h1001_0010;
    write_data   = 32'h1234_5678;
    DMEM_WRITE   = 1'b1;
    #1;
    check("ram_old", read_data, 32'hDEAD_BEEF);
    tick();
    DMEM_WRITE = 1'b0;
    rd("ram_new", 32'h1001_0010, 32'h1234_5678);
    wr(32'h1001_0014, 32'hCAFE_0001);
    rd("ram_nbr", 32'h1001_0010, 32'h1234_5678);

    // GPIO
    wr(A_GPIO, 32'h0000_00A5);
    check("gpio_out", gpio_out, 32'h0000_00A5);
    rd("gpio_rd", A_GPIO, 32'h0000_00A5);

    // One-shot timer, TLOAD=3
    wr(A_TLOAD, 32'd3);
    wr(A_TCTRL, 32'h5);
    rd("os_tval3", A_TVAL, 32'd3);
    tick();
    rd("os_tval2", A_TVAL, 32'd2);
    tick();
    rd("os_tval1", A_TVAL, 32'd1);
    tick();
    rd("os_tval0", A_TVAL, 32'd0);
    check("os_irq_e3", {31'b0, timer_irq}, 32'h0);
    tick();
    check("os_irq_e4", {31'b0, timer_irq}, 32'h1);
    rd("os_tstat", A_TSTAT, 32'h1);
    rd("os_tctrl", A_TCTRL, 32'h4);
    tick();
    rd("os_done", A_TVAL, 32'd0);
    wr(A_TSTAT, 32'h1);
    check("os_clr_irq", {31'b0, timer_irq}, 32'h0);
    rd("os_clr_stat", A_TSTAT, 32'h0);

    // Auto-reload timer, TLOAD=2
    wr(A_TLOAD, 32'd2);
    wr(A_TCTRL, 32'h7);
    rd("ar_tval2", A_TVAL, 32'd2);
    tick();
    tick();
    rd("ar_tval0", A_TVAL, 32'd0);
    rd("ar_pre", A_TSTAT, 32'h0);
    tick();
    rd("ar_exp1", A_TSTAT, 32'h1);
    rd("ar_reload", A_TVAL, 32'd2);
    wr(A_TSTAT, 32'h1);
    rd("ar_clr", A_TSTAT, 32'h0);
    tick();
    rd("ar_tval0b", A_TVAL, 32'd0);
    wr(A_TSTAT, 32'h1);
    rd("ar_setwins", A_TSTAT, 32'h1);
    rd("ar_reload2", A_TVAL, 32'd2);

    // Disable: IDLE, TVAL holds
    wr(A_TCTRL, 32'h0);
    rd("dis_tval", A_TVAL, 32'd2);
    tick();
    rd("dis_hold", A_TVAL, 32'd2);

    // Restart during RUN, then reset during RUN
    wr(A_TLOAD, 32'd9);
    wr(A_TCTRL, 32'h5);
    check("run_irq", {31'b0, timer_irq}, 32'h1);
    tick();
    rd("run_tval8", A_TVAL, 32'd8);
    wr(A_TCTRL, 32'h5);
    rd("restart", A_TVAL, 32'd9);
    reset = 1'b1;
    tick();
    check("rr_irq", {31'b0, timer_irq}, 32'h0);
    check("rr_gpio", gpio_out, 32'h0);
    rd("rr_tval", A_TVAL, 32'd0);
    rd("rr_tload", A_TLOAD, 32'd0);
    rd("rr_tctrl", A_TCTRL, 32'd0);
    reset = 1'b0;
    tick();
    tick();
    rd("rr_idle", A_TVAL, 32'd0);

    // Store beyond the RAM window
    wr(32'h1001_0000, 32'h1111_1111);
    check("oob_pre", {31'b0, bus_err}, 32'h0);
    wr(32'h1002_0000, 32'h2222_2222);
`ifdef DMEM_BOUNDS_CHECK_EN
    check("oob_err", {31'b0, bus_err}, 32'h1);
    rd("oob_word0", 32'h1001_0000, 32'h1111_1111);
    rd("oob_rd0", 32'h1002_0000, 32'h0);
    tick();
    check("oob_sticky", {31'b0, bus_err}, 32'h1);
`else
    check("alias_err", {31'b0, bus_err}, 32'h0);
    rd("alias_word0", 32'h1001_0000, 32'h2222_2222);
    rd("alias_rd", 32'h1002_0000, 32'h2222_2222);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
